// File: rtl/bcd_time_counter.sv
// rtl/bcd_time_counter.sv - 24-hour BCD hours/minutes counter with prescaler, seconds and validated load
module bcd_time_counter #(
    parameter int CLK_PER_SEC = 256,
    parameter int SEC_PER_MIN = 60
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        run,
    input  logic        load,
    input  logic [15:0] load_time,
    output logic [15:0] current_time,
    output logic [5:0]  seconds,
    output logic        minute_tick,
    output logic        load_error
);

    localparam int PW = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(CLK_PER_SEC - 1);
    localparam logic [5:0]    SEC_LAST = 6'(SEC_PER_MIN - 1);

    logic [PW-1:0] prescaler;
    logic          sec_end;
    logic          min_end;
    logic          load_ok;
    logic [15:0]   next_time;

    assign sec_end = run && (prescaler == PRE_LAST);
    assign min_end = sec_end && (seconds == SEC_LAST);

    always_comb begin
        load_ok = (load_time[15:12] <= 4'd2) && (load_time[11:8] <= 4'd9) &&
                  (load_time[7:4] <= 4'd5) && (load_time[3:0] <= 4'd9) &&
                  !((load_time[15:12] == 4'd2) && (load_time[11:8] > 4'd3));
    end

    // Ripple the BCD carry M0 -> M1 -> H0 -> H1; 23:59 is the only hour wrap.
    always_comb begin
        next_time = current_time;
        if (current_time[3:0] != 4'd9) begin
            next_time[3:0] = current_time[3:0] + 4'd1;
        end else begin
            next_time[3:0] = 4'd0;
            if (current_time[7:4] != 4'd5) begin
                next_time[7:4] = current_time[7:4] + 4'd1;
            end else begin
                next_time[7:4] = 4'd0;
                if ((current_time[15:12] == 4'd2) && (current_time[11:8] == 4'd3)) begin
                    next_time[15:8] = 8'h00;
                end else if (current_time[11:8] == 4'd9) begin
                    next_time[11:8]  = 4'd0;
                    next_time[15:12] = current_time[15:12] + 4'd1;
                end else begin
                    next_time[11:8] = current_time[11:8] + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            current_time <= 16'h0000;
            seconds      <= 6'd0;
            prescaler    <= '0;
            minute_tick  <= 1'b0;
            load_error   <= 1'b0;
        end else begin
            minute_tick <= 1'b0;
            load_error  <= 1'b0;
            if (load && load_ok) begin
                current_time <= load_time;
                seconds      <= 6'd0;
                prescaler    <= '0;
            end else begin
                // A rejected load leaves counting untouched, including a minute advance.
                load_error <= load;
                if (run) begin
                    prescaler <= sec_end ? '0 : prescaler + PW'(1);
                    if (sec_end) begin
                        seconds <= min_end ? 6'd0 : seconds + 6'd1;
                    end
                    if (min_end) begin
                        current_time <= next_time;
                        minute_tick  <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_bcd_time_counter.sv
// tb/tb_bcd_time_counter.sv - self-checking bench for bcd_time_counter against a minutes-of-day model
module tb_bcd_time_counter;

    localparam int CPS = 2;
    localparam int SPM = 3;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        run = 1'b0;
    logic        load = 1'b0;
    logic [15:0] load_time = 16'h0000;
    logic [15:0] current_time;
    logic [5:0]  seconds;
    logic        minute_tick;
    logic        load_error;

    int vectors = 0;
    int miscompares = 0;

    bcd_time_counter #(.CLK_PER_SEC(CPS), .SEC_PER_MIN(SPM)) dut (
        .clock(clock),
        .reset(reset),
        .run(run),
        .load(load),
        .load_time(load_time),
        .current_time(current_time),
        .seconds(seconds),
        .minute_tick(minute_tick),
        .load_error(load_error)
    );

    always #5 clock = ~clock;

    // Model: run cycles elapsed in the minute plus minutes since midnight.
    int m_cnt = 0;
    int m_mins = 0;
    bit m_tick = 0;
    bit m_err = 0;

    function automatic bit valid_time(input logic [15:0] t);
        int h1, h0, mt, mo;
        h1 = int'(t[15:12]); h0 = int'(t[11:8]); mt = int'(t[7:4]); mo = int'(t[3:0]);
        return (h0 <= 9) && (mo <= 9) && (mt <= 5) && ((h1 * 10 + h0) < 24);
    endfunction

    function automatic int to_mins(input logic [15:0] t);
        return (int'(t[15:12]) * 10 + int'(t[11:8])) * 60 + int'(t[7:4]) * 10 + int'(t[3:0]);
    endfunction

    function automatic logic [15:0] to_bcd(input int mins);
        int h, m;
        logic [15:0] r;
        h = mins / 60;
        m = mins % 60;
        r[15:12] = 4'(h / 10);
        r[11:8]  = 4'(h % 10);
        r[7:4]   = 4'(m / 10);
        r[3:0]   = 4'(m % 10);
        return r;
    endfunction

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_cnt = 0; m_mins = 0; m_tick = 0; m_err = 0;
        end else begin
            m_tick = 0;
            m_err = 0;
            if (load && valid_time(load_time)) begin
                m_mins = to_mins(load_time);
                m_cnt = 0;
            end else begin
                m_err = load;
                if (run) begin
                    m_cnt = m_cnt + 1;
                    if (m_cnt == CPS * SPM) begin
                        m_cnt = 0;
                        m_mins = (m_mins + 1) % 1440;
                        m_tick = 1;
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [15:0] actual, input logic [15:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clock) begin
        check("model_time", current_time, to_bcd(m_mins));
        check("model_seconds", {10'd0, seconds}, 16'(m_cnt / CPS));
        check("model_tick", {15'd0, minute_tick}, {15'd0, m_tick});
        check("model_err", {15'd0, load_error}, {15'd0, m_err});
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #2;
        end
    endtask

    task automatic do_load(input logic [15:0] v);
        load = 1'b1;
        load_time = v;
        step(1);
        load = 1'b0;
    endtask

    initial begin
        step(2);
        check("reset_time", current_time, 16'h0000);
        check("reset_seconds", {10'd0, seconds}, 16'd0);
        reset = 1'b0;
        run = 1'b1;

        // Free run: two minutes in 12 cycles.
        step(6);
        check("run6_time", current_time, 16'h0001);
        check("run6_tick", {15'd0, minute_tick}, 16'd1);
        step(6);
        check("run12_time", current_time, 16'h0002);

        // Day wrap.
        do_load(16'h2359);
        check("load2359", current_time, 16'h2359);
        step(6);
        check("wrap_time", current_time, 16'h0000);
        check("wrap_tick", {15'd0, minute_tick}, 16'd1);

        // Carry chain.
        do_load(16'h0959); step(6); check("carry_0959", current_time, 16'h1000);
        do_load(16'h1959); step(6); check("carry_1959", current_time, 16'h2000);
        do_load(16'h0009); step(6); check("carry_0009", current_time, 16'h0010);

        // Rejected loads while stopped: time holds, error pulses.
        run = 1'b0;
        do_load(16'h2400); check("bad2400_err", {15'd0, load_error}, 16'd1); check("bad2400_time", current_time, 16'h0010);
        do_load(16'h1960); check("bad1960_err", {15'd0, load_error}, 16'd1);
        do_load(16'h3000); check("bad3000_err", {15'd0, load_error}, 16'd1);
        do_load(16'h0A00); check("bad0A00_err", {15'd0, load_error}, 16'd1); check("bad0A00_time", current_time, 16'h0010);
        step(1);
        check("err_cleared", {15'd0, load_error}, 16'd0);

        // Valid load collides with the minute end.
        run = 1'b1;
        do_load(16'h0007);
        step(5);
        do_load(16'h1234);
        check("collide_time", current_time, 16'h1234);
        check("collide_seconds", {10'd0, seconds}, 16'd0);
        check("collide_tick", {15'd0, minute_tick}, 16'd0);

        // Async reset mid-minute.
        do_load(16'h1545);
        step(3);
        reset = 1'b1;
        #1;
        check("async_time", current_time, 16'h0000);
        check("async_seconds", {10'd0, seconds}, 16'd0);
        step(1);
        reset = 1'b0;
        step(4);
        check("restart_seconds", {10'd0, seconds}, 16'd2);
        run = 1'b0;
        step(10);
        check("hold_seconds", {10'd0, seconds}, 16'd2);
        check("hold_time", current_time, 16'h0000);
        run = 1'b1;
        step(2);
        check("resume_time", current_time, 16'h0001);
        step(1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
